alu_exec_unit: RTL

- Execute-stage unit directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code, the 4-bit funct field and two 32-bit operands, and produces a registered result and flags.
- Logic ops, add and subtract complete in one cycle.
- Shifts run on an iterative shifter to save FPGA area, so latency varies with shift amount.
- A valid/ready handshake on both sides lets the pipeline stall around multi-cycle shifts.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_shift_seq.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: control codes,
// funct3 compare selectors, FSM states and shift kinds.
package alu_pkg;

    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;
    localparam logic [3:0] XOR = 4'b0010;
    localparam logic [3:0] LSL = 4'b0011;
    localparam logic [3:0] RSL = 4'b0100;
    localparam logic [3:0] RSA = 4'b0101;
    localparam logic [3:0] ADD = 4'b0110;
    localparam logic [3:0] SUB = 4'b0111;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SK_LSL = 2'd0,
        SK_RSL = 2'd1,
        SK_RSA = 2'd2
    } shift_kind_t;

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative shifter: moves the accumulator by at most SHIFT_STEP
// bit positions per cycle until the captured count is exhausted.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      shamt,
    input  shift_kind_t     kind,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] value
);

    localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

    logic [XLEN-1:0] r_acc;
    logic [5:0]      r_cnt;
    shift_kind_t     r_kind;
    logic [5:0]      w_k;
    logic [XLEN-1:0] w_next;

    assign w_k = (r_cnt > STEP_W) ? STEP_W : r_cnt;

    always_comb begin
        w_next = r_acc;
        case (r_kind)
            SK_LSL:  w_next = r_acc << w_k;
            SK_RSL:  w_next = r_acc >> w_k;
            SK_RSA:  w_next = $signed(r_acc) >>> w_k;
            default: w_next = r_acc;
        endcase
    end

    assign busy  = (r_cnt != 6'd0);
    assign done  = busy && (r_cnt <= STEP_W);
    assign value = w_next;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_kind <= SK_LSL;
        end else if (start) begin
            r_acc  <= src;
            r_cnt  <= {1'b0, shamt};
            r_kind <= kind;
        end else if (busy) begin
            r_acc <= w_next;
            r_cnt <= r_cnt - w_k;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/flags, valid/ready on both
// sides and a multi-cycle iterative path for nonzero shifts.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_cntl,
    input  logic [3:0]      funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu,
    output logic            illegal
);

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero, r_lt, r_ltu, r_illegal;
    logic            r_lt_p, r_ltu_p;

    logic            w_accept, w_start, w_lt, w_ltu, w_ill, w_is_shift;
    logic [XLEN-1:0] w_res;
    shift_kind_t     w_kind;
    logic            w_sh_busy, w_sh_done;
    logic [XLEN-1:0] w_sh_value;
    logic            w_unused;

    assign w_unused = funct[3];

    assign in_ready = rst_n && (r_state == IDLE)
                      && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_lt     = $signed(op_a) < $signed(op_b);
    assign w_ltu    = op_a < op_b;
    assign w_start  = w_accept && w_is_shift && (op_b[4:0] != 5'd0);

    // Shift codes fall through with op_a so shamt==0 completes in one cycle.
    always_comb begin
        w_res      = '0;
        w_ill      = 1'b0;
        w_is_shift = 1'b0;
        w_kind     = SK_LSL;
        case (alu_cntl)
            AND: w_res = op_a & op_b;
            OR:  w_res = op_a | op_b;
            XOR: w_res = op_a ^ op_b;
            ADD: w_res = op_a + op_b;
            LSL: begin
                w_res      = op_a;
                w_is_shift = 1'b1;
                w_kind     = SK_LSL;
            end
            RSL: begin
                w_res      = op_a;
                w_is_shift = 1'b1;
                w_kind     = SK_RSL;
            end
            RSA: begin
                w_res      = op_a;
                w_is_shift = 1'b1;
                w_kind     = SK_RSA;
            end
            SUB: begin
                case (funct[2:0])
                    F3_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
                    F3_SLTU: w_res = {{(XLEN-1){1'b0}}, w_ltu};
                    default: w_res = op_a - op_b;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    alu_shift_seq #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .start (w_start),
        .src   (op_a),
        .shamt (op_b[4:0]),
        .kind  (w_kind),
        .busy  (w_sh_busy),
        .done  (w_sh_done),
        .value (w_sh_value)
    );

    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) w_state_nx = SHIFT;
                SHIFT:   if (w_sh_done || !w_sh_busy) w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
            r_illegal   <= 1'b0;
            r_lt_p      <= 1'b0;
            r_ltu_p     <= 1'b0;
        end else if (w_start) begin
            r_out_valid <= 1'b0;
            r_lt_p      <= w_lt;
            r_ltu_p     <= w_ltu;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_lt        <= w_lt;
            r_ltu       <= w_ltu;
            r_illegal   <= w_ill;
        end else if (r_state == SHIFT && w_sh_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sh_value;
            r_zero      <= (w_sh_value == '0);
            r_lt        <= r_lt_p;
            r_ltu       <= r_ltu_p;
            r_illegal   <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ltu       = r_ltu;
    assign illegal   = r_illegal;

endmodule
